// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU-6050 sample assembler.
// Holds the frame-control state encoding, the default burst length, the
// register address the burst starts from, and the word-slot indices used to
// place the assembled sample words.
package mpu_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StCommit  = 2'd2
    } state_e;

    // One burst covers accel (6), temp (2) and gyro (6) registers.
    localparam int unsigned FRAME_BYTES_DEFAULT = 14;

    // Burst reads start at ACCEL_XOUT_H.
    localparam logic [7:0] DATA_BASE_ADDR = 8'h3B;

    localparam int unsigned NUM_WORDS = 7;

    localparam int unsigned AX   = 0;
    localparam int unsigned AY   = 1;
    localparam int unsigned AZ   = 2;
    localparam int unsigned TEMP = 3;
    localparam int unsigned GX   = 4;
    localparam int unsigned GY   = 5;
    localparam int unsigned GZ   = 6;

    // Display selector value that routes the sample counter.
    localparam logic [2:0] SEL_COUNT = 3'd7;

endpackage

// File: rtl/mpu_display_mux.sv
// Registered display byte selector.
// Ports:
//   clk, reset_bar  - clock and asynchronous active-low reset
//   disp_sel        - 0..6 picks a sample word, 7 picks sample_count
//   disp_hi         - 1 = high byte of the selected word, 0 = low byte
//   words           - committed sample words, word k at [k*WORD_W +: WORD_W]
//   sample_count    - committed-sample counter
//   display         - selected byte, one clock after the selection
module mpu_display_mux
    import mpu_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_bar,
    input  logic [2:0]                  disp_sel,
    input  logic                        disp_hi,
    input  logic [NUM_WORDS*WORD_W-1:0] words,
    input  logic [7:0]                  sample_count,
    output logic [7:0]                  display
);

    logic [WORD_W-1:0] sel_word;
    logic [7:0]        display_d;
    logic [7:0]        display_q;

    always_comb begin
        sel_word  = '0;
        display_d = sample_count;
        case (disp_sel)
            3'd0:    sel_word = words[AX*WORD_W   +: WORD_W];
            3'd1:    sel_word = words[AY*WORD_W   +: WORD_W];
            3'd2:    sel_word = words[AZ*WORD_W   +: WORD_W];
            3'd3:    sel_word = words[TEMP*WORD_W +: WORD_W];
            3'd4:    sel_word = words[GX*WORD_W   +: WORD_W];
            3'd5:    sel_word = words[GY*WORD_W   +: WORD_W];
            3'd6:    sel_word = words[GZ*WORD_W   +: WORD_W];
            default: sel_word = '0;
        endcase
        if (disp_sel != SEL_COUNT) begin
            display_d = disp_hi ? sel_word[15:8] : sel_word[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            display_q <= '0;
        end else begin
            display_q <= display_d;
        end
    end

    assign display = display_q;

endmodule

// File: rtl/mpu_sample_assembler.sv
// Assembles MPU-6050 burst-read bytes into seven big-endian sample words.
// Bytes land in a shadow buffer while a frame is collected; only a complete
// frame closed by frame_end is copied to the outputs, all words at once.
// Ports:
//   clk, reset_bar         - clock and asynchronous active-low reset
//   frame_start, frame_end - burst open / close pulses from the I2C controller
//   byte_valid, byte_data  - received byte strobe and value
//   disp_sel, disp_hi      - display source select
//   accel_*, temp, gyro_*  - last committed sample words
//   sample_valid           - pulse, new sample committed
//   frame_error            - pulse, burst aborted or malformed
//   busy                   - frame control not idle
//   sample_count           - committed-sample counter (wraps)
//   display                - registered display byte
module mpu_sample_assembler
    import mpu_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter int unsigned WORD_W      = 16
) (
    input  logic              clk,
    input  logic              reset_bar,
    input  logic              frame_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              frame_end,
    input  logic [2:0]        disp_sel,
    input  logic              disp_hi,
    output logic [WORD_W-1:0] accel_x,
    output logic [WORD_W-1:0] accel_y,
    output logic [WORD_W-1:0] accel_z,
    output logic [WORD_W-1:0] temp,
    output logic [WORD_W-1:0] gyro_x,
    output logic [WORD_W-1:0] gyro_y,
    output logic [WORD_W-1:0] gyro_z,
    output logic              sample_valid,
    output logic              frame_error,
    output logic              busy,
    output logic [7:0]        sample_count,
    output logic [7:0]        display
);

    localparam int unsigned IDX_W        = $clog2(FRAME_BYTES + 1);
    localparam int unsigned SHADOW_BYTES =
        (FRAME_BYTES > 2 * NUM_WORDS) ? FRAME_BYTES : 2 * NUM_WORDS;
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(FRAME_BYTES);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_eff;
    logic [7:0]        shadow_q [SHADOW_BYTES];
    logic              shadow_we;
    logic [IDX_W-1:0]  shadow_waddr;
    logic [WORD_W-1:0] words_q [NUM_WORDS];
    logic              commit;
    logic              err_d;
    // Both pulses pass through one extra stage so they leave together with
    // the committed words already stable, and stay mutually exclusive.
    logic              commit_q, err_q;
    logic              sample_valid_q, frame_error_q;
    logic [7:0]        count_q;
    logic [NUM_WORDS*WORD_W-1:0] words_flat;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        idx_eff      = idx_q;
        shadow_we    = 1'b0;
        shadow_waddr = idx_q;
        err_d        = 1'b0;
        commit       = (state_q == StCommit);

        if (frame_start) begin
            // Restart wins over everything else; frame_end is ignored here.
            err_d   = (state_q == StCollect) && (idx_q != '0);
            state_d = StCollect;
            idx_d   = '0;
            if (byte_valid) begin
                shadow_we    = 1'b1;
                shadow_waddr = '0;
                idx_d        = IDX_ONE;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StCollect: begin
                    if (byte_valid && (idx_q == IDX_FULL)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        if (byte_valid) begin
                            shadow_we = 1'b1;
                            idx_eff   = idx_q + IDX_ONE;
                        end
                        idx_d = idx_eff;
                        if (frame_end) begin
                            if (idx_eff == IDX_FULL) begin
                                state_d = StCommit;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                                idx_d   = '0;
                            end
                        end
                    end
                end
                StCommit: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            commit_q       <= 1'b0;
            err_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            commit_q       <= commit;
            err_q          <= err_d;
            sample_valid_q <= commit_q;
            frame_error_q  <= err_q;
            if (commit_q) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Shadow is cleared on reset so a reset mid-frame leaves nothing behind.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            for (int i = 0; i < SHADOW_BYTES; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (shadow_we) begin
            shadow_q[shadow_waddr] <= byte_data;
        end
    end

    // Byte 2k is the high byte, 2k+1 the low byte of word k.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                words_q[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                words_q[k] <= WORD_W'({shadow_q[2*k], shadow_q[2*k+1]});
            end
        end
    end

    always_comb begin
        words_flat = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            words_flat[k*WORD_W +: WORD_W] = words_q[k];
        end
    end

    mpu_display_mux #(
        .WORD_W (WORD_W)
    ) u_display_mux (
        .clk          (clk),
        .reset_bar    (reset_bar),
        .disp_sel     (disp_sel),
        .disp_hi      (disp_hi),
        .words        (words_flat),
        .sample_count (count_q),
        .display      (display)
    );

    assign accel_x      = words_q[AX];
    assign accel_y      = words_q[AY];
    assign accel_z      = words_q[AZ];
    assign temp         = words_q[TEMP];
    assign gyro_x       = words_q[GX];
    assign gyro_y       = words_q[GY];
    assign gyro_z       = words_q[GZ];
    assign sample_valid = sample_valid_q;
    assign frame_error  = frame_error_q;
    assign busy         = (state_q != StIdle);
    assign sample_count = count_q;

endmodule

// File: doc/mpu_sample_assembler.md
MPU_SAMPLE_ASSEMBLER -- requirements
Module: mpu_sample_assembler

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 14, meaning bytes per MPU-6050 burst read starting at register 0x3B.
REQ-002 SHALL have parameter WORD_W, default 16, meaning width of each assembled sample word.
REQ-003 SHALL have one clock and one asynchronous, active-low reset; ports clk and reset_bar.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_bar  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse, new burst begins.
REQ-007 byte_valid  input  1  byte_data valid this cycle, accepted unconditionally.
REQ-008 byte_data  input  8  byte read from the I2C controller.
REQ-009 frame_end  input  1  one-cycle pulse, burst closed (NACK/STOP issued).
REQ-010 disp_sel  input  3  display source: 0..6 = accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z; 7 = sample_count.
REQ-011 disp_hi  input  1  1 selects the high byte of the selected word, 0 the low byte (ignored for sel 7).
REQ-012 accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z  output  WORD_W each  last committed sample.
REQ-013 sample_valid  output  1  one-cycle pulse, new sample committed.
REQ-014 frame_error  output  1  one-cycle pulse, burst aborted or malformed.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 sample_count  output  8  committed-sample counter.
REQ-017 display  output  8  registered display byte.

Function
REQ-018 SHALL implement states IDLE, COLLECT, COMMIT.
REQ-019 SHALL, on frame_start in any state, clear the byte index and enter COLLECT; if the index was nonzero in COLLECT, it SHALL also pulse frame_error.
REQ-020 SHALL, in COLLECT with byte_valid, store byte_data into shadow slot [index] and increment the index; byte 2k is the high byte and byte 2k+1 the low byte of word k (big-endian).
REQ-021 SHALL, on simultaneous frame_start and byte_valid, store the byte as slot 0 (index becomes 1).
REQ-022 SHALL, on simultaneous frame_start and frame_end, ignore frame_end.
REQ-023 SHALL ignore byte_valid and frame_end in IDLE and COMMIT.
REQ-024 SHALL, on byte_valid with index == FRAME_BYTES (overrun), pulse frame_error, return to IDLE, and not commit.
REQ-025 SHALL, on frame_end in COLLECT, enter COMMIT if the index (counting a byte accepted the same cycle) equals FRAME_BYTES; otherwise it SHALL pulse frame_error and return to IDLE.
REQ-026 SHALL, in COMMIT, load all seven output words from the shadow atomically, pulse sample_valid for exactly one cycle, increment sample_count (wrapping 255 -> 0), and return to IDLE; latency is 2 clocks from the edge that samples frame_end to the edge on which sample_valid goes high.
REQ-027 Output words SHALL change only in COMMIT; aborted frames SHALL leave them unchanged.
REQ-028 display SHALL be updated on every clock from disp_sel/disp_hi (1-cycle latency).
REQ-029 frame_error and sample_valid SHALL never be high in the same cycle.

Reset
REQ-030 Asserting reset_bar low SHALL immediately force state IDLE, index 0, all output words 0, sample_count 0, display 0, and sample_valid, frame_error, busy low.
REQ-031 Reset asserted mid-frame SHALL discard the shadow contents; no sample_valid or frame_error SHALL follow release.

Structure
REQ-032 Shared package mpu_pkg SHALL hold the state encoding, FRAME_BYTES, the data base address 8'h3B, and the word-index constants (AX=0 .. GZ=6).
REQ-033 The display selection SHALL be a single sub-module, mpu_display_mux; frame control and the shadow buffer SHALL stay in mpu_sample_assembler.

Verification
REQ-034 Stimulus: frame_start, bytes 01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E, frame_end. Required: accel_x=0x0102 ... gyro_z=0x0D0E, one sample_valid pulse, sample_count=1.
REQ-035 Stimulus: frame_start, 10 bytes, frame_end. Required: one frame_error pulse, no sample_valid, outputs unchanged.
REQ-036 Stimulus: 14 bytes followed by a 15th byte. Required: frame_error pulse, state IDLE, frame_end ignored afterwards.
REQ-037 Stimulus: frame_start at byte 6, then a full 14-byte frame starting with 0xAA in the same cycle. Required: frame_error pulse at restart, accel_x=0xAA.., commit succeeds.
REQ-038 Stimulus: 256 good frames. Required: sample_count wraps to 0; display with sel=7 reads 0x00; sel=0, disp_hi=1 reads the accel_x high byte.
REQ-039 Stimulus: reset_bar low after byte 7. Required: all outputs 0 immediately; no pulse after release.
